// File: rtl/lcd_status_pkg.sv
// lcd_status_pkg
// Shared definitions for the LCD status writer: sequencer state type,
// HD44780 init command bytes, line addresses, fixed ASCII strings and
// sequence lengths. Byte constants are 9 bits wide: bit 8 is RS
// (0 = command, 1 = character data), bits 7:0 are the byte itself.
package lcd_status_pkg;

  typedef enum logic [2:0] {
    S_PWR,
    S_LOAD,
    S_START,
    S_WAIT,
    S_GAP,
    S_IDLE
  } lcdState_t;

  // Power-up command sequence (RS = 0 for all of them)
  localparam logic [8:0] CMD_FUNC_SET   = 9'h038;
  localparam logic [8:0] CMD_DISPLAY_ON = 9'h00C;
  localparam logic [8:0] CMD_CLEAR      = 9'h001;
  localparam logic [8:0] CMD_ENTRY_MODE = 9'h006;

  // DDRAM addresses of the two display lines
  localparam logic [8:0] ADDR_LINE1 = 9'h080;
  localparam logic [8:0] ADDR_LINE2 = 9'h0C0;

  // Fixed text fragments
  localparam logic [7:0]   ASCII_ZERO      = 8'h30;
  localparam logic [47:0]  STR_FLOOR       = "FLOOR ";
  localparam logic [15:0]  STR_SPACE2      = "  ";
  localparam logic [23:0]  STR_SPACE3      = "   ";
  localparam logic [31:0]  STR_DIR_IDLE    = "IDLE";
  localparam logic [31:0]  STR_DIR_UP      = "UP  ";
  localparam logic [31:0]  STR_DIR_DOWN    = "DOWN";
  localparam logic [31:0]  STR_DIR_FAULT   = "FLT!";
  localparam logic [127:0] STR_DOOR_OPEN   = "DOOR OPEN       ";
  localparam logic [127:0] STR_DOOR_CLOSED = "DOOR CLOSED     ";

  // Sequence lengths and the last index of each sequence
  localparam int         INIT_LEN   = 5;
  localparam int         FRAME_LEN  = 34;
  localparam logic [5:0] INIT_LAST  = 6'(INIT_LEN - 1);
  localparam logic [5:0] FRAME_LAST = 6'(FRAME_LEN - 1);

endpackage

// File: rtl/lcd_status_rom.sv
// lcd_status_rom
// Combinational byte table for the LCD status writer.
// Ports:
//   phase    in  1  0 = init sequence, 1 = frame sequence
//   index    in  6  byte position within the selected sequence
//   snapshot in  6  {floor[2:0], dir[1:0], doorOpen} used to render the frame
//   romByte  out 9  {RS, DATA} for the selected byte
import lcd_status_pkg::*;

module lcd_status_rom (
  input  logic       phase,
  input  logic [5:0] index,
  input  logic [5:0] snapshot,
  output logic [8:0] romByte
);

  logic [31:0]  dirStr;
  logic [7:0]   floorChar;
  logic [127:0] line1;
  logic [127:0] line2;
  logic [127:0] line1Shift;
  logic [127:0] line2Shift;

  // Build both text lines from the snapshot, then pick the requested byte.
  // Each line is a 16-character packed string with the first character in
  // the top byte, so shifting left by 8*position brings the wanted
  // character to bits 127:120.
  always_comb begin
    dirStr = STR_DIR_IDLE;
    case (snapshot[2:1])
      2'b01:   dirStr = STR_DIR_UP;
      2'b10:   dirStr = STR_DIR_DOWN;
      2'b11:   dirStr = STR_DIR_FAULT;
      default: dirStr = STR_DIR_IDLE;
    endcase

    floorChar  = ASCII_ZERO + {5'd0, snapshot[5:3]};
    line1      = {STR_FLOOR, floorChar, STR_SPACE2, dirStr, STR_SPACE3};
    line2      = snapshot[0] ? STR_DOOR_OPEN : STR_DOOR_CLOSED;
    line1Shift = line1 << {index - 6'd1, 3'b000};
    line2Shift = line2 << {index - 6'd18, 3'b000};

    romByte = 9'h000;
    if (!phase) begin
      case (index)
        6'd0:    romByte = CMD_FUNC_SET;
        6'd1:    romByte = CMD_DISPLAY_ON;
        6'd2:    romByte = CMD_CLEAR;
        6'd3:    romByte = CMD_ENTRY_MODE;
        6'd4:    romByte = ADDR_LINE1;
        default: romByte = 9'h000;
      endcase
    end else begin
      if (index == 6'd0) begin
        romByte = ADDR_LINE1;
      end else if (index <= 6'd16) begin
        romByte = {1'b1, line1Shift[127:120]};
      end else if (index == 6'd17) begin
        romByte = ADDR_LINE2;
      end else if (index <= FRAME_LAST) begin
        romByte = {1'b1, line2Shift[127:120]};
      end
    end
  end

endmodule

// File: rtl/lcd_status_writer.sv
// lcd_status_writer
// Byte sequencer in front of the 16x2 character LCD controller. After reset
// it waits for the panel to power up, sends the HD44780 init commands, then
// renders floor / direction / door state as two text lines. The display is
// redrawn only when the inputs differ from the state last drawn.
// Ports:
//   iCLK        in  1  system clock
//   iRST_N      in  1  asynchronous active-low reset
//   iFLOOR      in  3  current floor 0-7
//   iDIR        in  2  00 idle, 01 up, 10 down, 11 fault
//   iDOOR_OPEN  in  1  1 = door open
//   iLCD_DONE   in  1  controller done flag (a 0->1 edge completes a byte)
//   oLCD_DATA   out 8  byte to the controller
//   oLCD_RS     out 1  0 = command, 1 = data
//   oLCD_START  out 1  controller start request
//   oBUSY       out 1  high during init and while a frame is being sent
//   oERR        out 1  sticky done-timeout flag
// Build option: define LCD_STATUS_TIMEOUT_EN to abandon a byte whose done
// edge does not arrive within TIMEOUT cycles and raise oERR. Without it the
// writer waits for done indefinitely and oERR stays 0.
import lcd_status_pkg::*;

module lcd_status_writer #(
  parameter logic [19:0] POWERUP_WAIT = 20'd750000,
  parameter logic [19:0] BYTE_GAP     = 20'd2000,
  parameter logic [19:0] CLEAR_GAP    = 20'd100000,
  parameter logic [19:0] TIMEOUT      = 20'd4000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [2:0] iFLOOR,
  input  logic [1:0] iDIR,
  input  logic       iDOOR_OPEN,
  input  logic       iLCD_DONE,
  output logic [7:0] oLCD_DATA,
  output logic       oLCD_RS,
  output logic       oLCD_START,
  output logic       oBUSY,
  output logic       oERR
);

  lcdState_t   state, nextState;
  logic [19:0] counter, nextCounter;
  logic [5:0]  index, nextIndex;
  logic        phase, nextPhase;
  logic [5:0]  snapshot, nextSnapshot;
  logic [7:0]  lcdData, nextLcdData;
  logic        lcdRs, nextLcdRs;
  logic        lcdStart, nextLcdStart;
  logic        busy, nextBusy;
  logic        err, nextErr;
  logic        doneQ;

  logic [8:0]  romByte;
  logic [5:0]  liveState;
  logic        doneRise;
  logic [19:0] gapLimit;

  lcd_status_rom rom (
    .phase    (phase),
    .index    (index),
    .snapshot (snapshot),
    .romByte  (romByte)
  );

  assign liveState = {iFLOOR, iDIR, iDOOR_OPEN};
  assign doneRise  = iLCD_DONE & ~doneQ;
  assign gapLimit  = ({lcdRs, lcdData} == CMD_CLEAR) ? CLEAR_GAP : BYTE_GAP;

  assign oLCD_DATA  = lcdData;
  assign oLCD_RS    = lcdRs;
  assign oLCD_START = lcdStart;
  assign oBUSY      = busy;
  assign oERR       = err;

  // State and datapath registers. doneQ keeps last cycle's done so that
  // only a fresh 0->1 transition counts as completion.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= S_PWR;
      counter  <= 20'd0;
      index    <= 6'd0;
      phase    <= 1'b0;
      snapshot <= 6'd0;
      lcdData  <= 8'd0;
      lcdRs    <= 1'b0;
      lcdStart <= 1'b0;
      busy     <= 1'b1;
      err      <= 1'b0;
      doneQ    <= 1'b0;
    end else begin
      state    <= nextState;
      counter  <= nextCounter;
      index    <= nextIndex;
      phase    <= nextPhase;
      snapshot <= nextSnapshot;
      lcdData  <= nextLcdData;
      lcdRs    <= nextLcdRs;
      lcdStart <= nextLcdStart;
      busy     <= nextBusy;
      err      <= nextErr;
      doneQ    <= iLCD_DONE;
    end
  end

  // Next-state logic. One shared counter times the power-up wait, the
  // done wait and the inter-byte gap; it is cleared whenever one of those
  // phases ends so the next phase starts from zero.
  always_comb begin
    nextState    = state;
    nextCounter  = counter;
    nextIndex    = index;
    nextPhase    = phase;
    nextSnapshot = snapshot;
    nextLcdData  = lcdData;
    nextLcdRs    = lcdRs;
    nextLcdStart = lcdStart;
    nextBusy     = busy;
    nextErr      = err;

    case (state)
      S_PWR: begin
        if (counter == POWERUP_WAIT - 20'd1) begin
          nextCounter = 20'd0;
          nextState   = S_LOAD;
        end else begin
          nextCounter = counter + 20'd1;
        end
      end

      S_LOAD: begin
        nextLcdRs   = romByte[8];
        nextLcdData = romByte[7:0];
        nextState   = S_START;
      end

      S_START: begin
        nextLcdStart = 1'b1;
        nextCounter  = 20'd0;
        nextState    = S_WAIT;
      end

      S_WAIT: begin
        if (doneRise) begin
          nextLcdStart = 1'b0;
          nextCounter  = 20'd0;
          nextState    = S_GAP;
`ifdef LCD_STATUS_TIMEOUT_EN
        end else if (counter == TIMEOUT - 20'd1) begin
          // Give up on this byte but keep the sequence moving.
          nextLcdStart = 1'b0;
          nextErr      = 1'b1;
          nextCounter  = 20'd0;
          nextState    = S_GAP;
`endif
        end else if (counter != TIMEOUT) begin
          // Elapsed wait saturates rather than wrapping.
          nextCounter = counter + 20'd1;
        end
      end

      S_GAP: begin
        if (counter == gapLimit) begin
          nextCounter = 20'd0;
          if (!phase) begin
            nextState = S_LOAD;
            if (index == INIT_LAST) begin
              // Init finished: the first frame draws the state as of now.
              nextPhase    = 1'b1;
              nextIndex    = 6'd0;
              nextSnapshot = liveState;
            end else begin
              nextIndex = index + 6'd1;
            end
          end else if (index == FRAME_LAST) begin
            nextState = S_IDLE;
            nextBusy  = 1'b0;
          end else begin
            nextIndex = index + 6'd1;
            nextState = S_LOAD;
          end
        end else begin
          nextCounter = counter + 20'd1;
        end
      end

      S_IDLE: begin
        if (liveState != snapshot) begin
          nextSnapshot = liveState;
          nextBusy     = 1'b1;
          nextIndex    = 6'd0;
          nextPhase    = 1'b1;
          nextState    = S_LOAD;
        end
      end

      default: begin
        nextState = S_PWR;
      end
    endcase
  end

endmodule

// File: tb/tb_lcd_status_writer.sv
// tb_lcd_status_writer
// Self-checking bench for lcd_status_writer with small timing parameters.
// A behavioural controller answers each start request: done falls one cycle
// after the start rising edge and rises 20 cycles later. Every byte request
// is logged and compared against frames built from text strings.
module tb_lcd_status_writer;

  localparam logic [19:0] P_PWR  = 20'd10;
  localparam logic [19:0] P_BGAP = 20'd4;
  localparam logic [19:0] P_CGAP = 20'd8;
  localparam logic [19:0] P_TO   = 20'd16;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic [2:0] iFLOOR = 3'd0;
  logic [1:0] iDIR = 2'd0;
  logic       iDOOR_OPEN = 1'b0;
  logic       iLCD_DONE = 1'b1;
  logic [7:0] oLCD_DATA;
  logic       oLCD_RS;
  logic       oLCD_START;
  logic       oBUSY;
  logic       oERR;

  int checkCount = 0;
  int passCount = 0;
  int cycle = 0;
  int releaseCycle = 0;

  logic [8:0] byteLog[$];
  int         riseTimes[$];
  int         fallTimes[$];
  logic [8:0] expFrame[34];
  logic [8:0] initExp[5] = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};

  logic startPrev = 1'b0;
  bit   modelActive = 0;
  int   modelCnt = 0;
  int   holdDelay = 1;
  int   curFall = 1;
  bit   neverDone = 0;
  bit   curNever = 0;

  lcd_status_writer #(
    .POWERUP_WAIT (P_PWR),
    .BYTE_GAP     (P_BGAP),
    .CLEAR_GAP    (P_CGAP),
    .TIMEOUT      (P_TO)
  ) dut (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .iFLOOR     (iFLOOR),
    .iDIR       (iDIR),
    .iDOOR_OPEN (iDOOR_OPEN),
    .iLCD_DONE  (iLCD_DONE),
    .oLCD_DATA  (oLCD_DATA),
    .oLCD_RS    (oLCD_RS),
    .oLCD_START (oLCD_START),
    .oBUSY      (oBUSY),
    .oERR       (oERR)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cycle <= cycle + 1;

  // Controller model, evaluated on the falling edge away from the DUT's
  // active edge. The fall delay and the "never answer" option are latched
  // per request so they can be changed while a byte is in flight.
  always @(negedge iCLK) begin
    if (oLCD_START && !startPrev) begin
      byteLog.push_back({oLCD_RS, oLCD_DATA});
      riseTimes.push_back(cycle);
      modelActive = 1;
      modelCnt = 0;
      curFall = holdDelay;
      curNever = neverDone;
    end else if (modelActive) begin
      modelCnt++;
      if (modelCnt == curFall) iLCD_DONE = 1'b0;
      if (modelCnt == curFall + 20 && !curNever) begin
        iLCD_DONE = 1'b1;
        modelActive = 0;
      end
    end
    if (!oLCD_START && startPrev) fallTimes.push_back(cycle);
    startPrev = oLCD_START;
  end

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Change the elevator inputs on a falling edge
  task automatic applyStimulus(input logic [2:0] f, input logic [1:0] d, input logic o);
    @(negedge iCLK);
    iFLOOR = f;
    iDIR = d;
    iDOOR_OPEN = o;
  endtask

  // Assert reset, verify the reset values, clear the logs and release
  task automatic applyReset();
    @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    checkOutput("rstData", {24'd0, oLCD_DATA}, 32'd0);
    checkOutput("rstRs", {31'd0, oLCD_RS}, 32'd0);
    checkOutput("rstStart", {31'd0, oLCD_START}, 32'd0);
    checkOutput("rstBusy", {31'd0, oBUSY}, 32'd1);
    checkOutput("rstErr", {31'd0, oERR}, 32'd0);
    repeat (3) @(negedge iCLK);
    byteLog.delete();
    riseTimes.delete();
    fallTimes.delete();
    releaseCycle = cycle;
    iRST_N = 1'b1;
  endtask

  // Wait until oBUSY has been low for 5 consecutive cycles, bounded
  task automatic waitIdle(input string tag, input int budget);
    int streak = 0;
    int n = 0;
    while (streak < 5 && n < budget) begin
      @(negedge iCLK);
      n++;
      streak = oBUSY ? 0 : streak + 1;
    end
    checkOutput({tag, "IdleBound"}, {31'd0, streak >= 5}, 32'd1);
  endtask

  // Wait until the byte log holds at least target entries, bounded
  task automatic waitBytes(input string tag, input int target, input int budget);
    int n = 0;
    while (byteLog.size() < target && n < budget) begin
      @(negedge iCLK);
      n++;
    end
    checkOutput({tag, "ByteBound"}, {31'd0, byteLog.size() >= target}, 32'd1);
  endtask

  // Reference frame: address, formatted line 1, address, door line 2
  function automatic void buildFrame(input int f, input int d, input int o);
    string dirName;
    string l1;
    string l2;
    case (d)
      0: dirName = "IDLE";
      1: dirName = "UP  ";
      2: dirName = "DOWN";
      default: dirName = "FLT!";
    endcase
    l1 = $sformatf("FLOOR %0d  %s   ", f, dirName);
    l2 = (o != 0) ? "DOOR OPEN       " : "DOOR CLOSED     ";
    expFrame[0] = 9'h080;
    expFrame[17] = 9'h0C0;
    for (int i = 0; i < 16; i++) begin
      expFrame[1 + i] = {1'b1, l1[i]};
      expFrame[18 + i] = {1'b1, l2[i]};
    end
  endfunction

  task automatic checkFrame(input string tag, input int base, input int f, input int d, input int o);
    logic [8:0] got;
    buildFrame(f, d, o);
    for (int i = 0; i < 34; i++) begin
      got = (base + i < byteLog.size()) ? byteLog[base + i] : 9'h1FF;
      checkOutput($sformatf("%s[%0d]", tag, i), {23'd0, got}, {23'd0, expFrame[i]});
    end
  endtask

  task automatic checkInit(input string tag);
    int normalLow;
    int clearLow;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("%sInit[%0d]", tag, i),
                  {23'd0, (i < byteLog.size()) ? byteLog[i] : 9'h1FF}, {23'd0, initExp[i]});
    end
    if (riseTimes.size() >= 4 && fallTimes.size() >= 3) begin
      checkOutput({tag, "PwrWait"},
                  {31'd0, (riseTimes[0] - releaseCycle > int'(P_PWR)) && (riseTimes[0] - releaseCycle <= int'(P_PWR) + 3)}, 32'd1);
      normalLow = riseTimes[2] - fallTimes[1];
      clearLow = riseTimes[3] - fallTimes[2];
      checkOutput({tag, "ByteGapLow"},
                  {31'd0, (normalLow >= int'(P_BGAP) + 2) && (normalLow <= int'(P_BGAP) + 3)}, 32'd1);
      checkOutput({tag, "ClearGapExtra"}, clearLow - normalLow, P_CGAP - P_BGAP);
    end else begin
      checkOutput({tag, "InitTiming"}, riseTimes.size(), 32'd4);
    end
  endtask

  initial begin
    int mark;
    int len;
    logic [2:0] f;
    logic [1:0] d;
    logic o;

    // Power-up: inputs held at floor 3, going up, door closed
    iFLOOR = 3'd3;
    iDIR = 2'b01;
    iDOOR_OPEN = 1'b0;
    applyReset();
    waitIdle("init", 4000);
    checkInit("boot");
    checkFrame("frame1", 5, 3, 1, 0);
    repeat (200) @(negedge iCLK);
    checkOutput("noExtraStarts", byteLog.size(), 32'd39);
    checkOutput("idleBusy", {31'd0, oBUSY}, 32'd0);

    // Door opens while idle: busy next cycle, one frame without init
    mark = byteLog.size();
    applyStimulus(3'd3, 2'b01, 1'b1);
    @(negedge iCLK);
    checkOutput("busyNextCycle", {31'd0, oBUSY}, 32'd1);
    waitIdle("door", 3000);
    checkOutput("doorFrameLen", byteLog.size() - mark, 32'd34);
    checkFrame("doorFrame", mark, 3, 1, 1);

    // Floor changes at frame byte 10: current frame keeps the old floor
    mark = byteLog.size();
    applyStimulus(3'd3, 2'b10, 1'b1);
    waitBytes("midFrame", mark + 11, 2000);
    iFLOOR = 3'd4;
    waitIdle("midFrame", 6000);
    checkOutput("midFrameLen", byteLog.size() - mark, 32'd68);
    checkFrame("midOld", mark, 3, 2, 1);
    checkFrame("midNew", mark + 34, 4, 2, 1);

    // Done still high from the previous byte must not complete the next one
    mark = byteLog.size();
    holdDelay = 30;
    applyStimulus(3'd4, 2'b10, 1'b0);
    waitBytes("stale", mark + 1, 200);
    holdDelay = 1;
    repeat (25) @(negedge iCLK);
    checkOutput("staleDoneHold", {31'd0, oLCD_START}, 32'd1);
    waitIdle("stale", 3000);
    checkFrame("staleFrame", mark, 4, 2, 0);

    // Random input changes while idle
    for (int r = 0; r < 4; r++) begin
      do begin
        f = 3'($urandom_range(7, 0));
        d = 2'($urandom_range(3, 0));
        o = 1'($urandom_range(1, 0));
      end while ({f, d, o} == {iFLOOR, iDIR, iDOOR_OPEN});
      mark = byteLog.size();
      applyStimulus(f, d, o);
      @(negedge iCLK);
      checkOutput($sformatf("rndBusy%0d", r), {31'd0, oBUSY}, 32'd1);
      waitIdle($sformatf("rnd%0d", r), 3000);
      checkOutput($sformatf("rndLen%0d", r), byteLog.size() - mark, 32'd34);
      checkFrame($sformatf("rnd%0d", r), mark, int'(f), int'(d), int'(o));
    end

`ifdef LCD_STATUS_TIMEOUT_EN
    // Controller never answers one byte: abandoned after TIMEOUT cycles
    mark = byteLog.size();
    neverDone = 1;
    applyStimulus(iFLOOR + 3'd1, iDIR, iDOOR_OPEN);
    len = 0;
    while (!oLCD_START && len < 200) begin
      @(negedge iCLK);
      len++;
    end
    neverDone = 0;
    len = 0;
    while (oLCD_START && len < 100) begin
      len++;
      @(negedge iCLK);
    end
    checkOutput("timeoutLen", len, P_TO);
    checkOutput("errSticky", {31'd0, oERR}, 32'd1);
    waitIdle("timeout", 3000);
    checkOutput("timeoutFrameLen", byteLog.size() - mark, 32'd34);
    checkFrame("timeoutFrame", mark, int'(iFLOOR), int'(iDIR), int'(iDOOR_OPEN));
    checkOutput("errStillSet", {31'd0, oERR}, 32'd1);
`else
    checkOutput("errTiedLow", {31'd0, oERR}, 32'd0);
`endif

    // Reset in the middle of a frame redoes the whole init
    mark = byteLog.size();
    applyStimulus(iFLOOR, iDIR + 2'd1, ~iDOOR_OPEN);
    waitBytes("midReset", mark + 5, 2000);
    applyReset();
    waitIdle("reboot", 4000);
    checkInit("reboot");
    checkOutput("rebootLen", byteLog.size(), 32'd39);
    checkFrame("rebootFrame", 5, int'(iFLOOR), int'(iDIR), int'(iDOOR_OPEN));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
